dispatch_buffer: RTL
====================

# dispatch_buffer

Parametrised N-wide dispatch stage sitting between Rename and the backend issue queues (ALU RS, MDU RS, LSQ) and the ROB. It registers one renamed bundle from Rename and routes its instructions to the issue queues using per-queue free-slot credits. When resources are short it dispatches the oldest in-order prefix of the bundle and keeps the rest buffered, so it supports partial dispatch. It also owns the ROB tail pointer, tags every dispatched instruction with its ROB index, and recovers that pointer on flush.

## Interface
- DISPATCH_WIDTH, 2, instructions per bundle (W); ≥1
- ROB_DEPTH, 32, ROB entries; power of two
- ROB_IDX_W, $clog2(ROB_DEPTH), ROB tag width
- CREDIT_W, $clog2(DISPATCH_WIDTH+1), credit input width
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush
- flush_rob_tail  in  ROB_IDX_W  ROB tail value to restore on flush
- in_valid  in  1  Rename bundle valid
- in_rdy  out  1  bundle accepted at this edge when in_valid && in_rdy
- in_insts  in  renamed_inst_t[W]  bundle; valid instructions compacted to low slots
- alu_rs_credit, mdu_rs_credit, lsq_credit, rob_credit  in  CREDIT_W each  free slots this cycle; saturated at W
- alu_rs_we, mdu_rs_we, lsq_we  out  W each  per-slot write enable; slot k drives write port k
- alu_rs_entries, mdu_rs_entries, lsq_entries  out  renamed_inst_t[W]  = buffer slots, unconditionally
- rob_we  out  W  per-slot ROB write enable
- rob_entries  out  rob_entry_t[W]  generated ROB entries
- disp_rob_tag  out  ROB_IDX_W[W]  ROB index of slot k
- stall_cycles  out  32  saturating stall counter

## Operation
- State: W slot registers with valid bits, rob_tail (ROB_IDX_W), stall_cycles.
- Class of each instruction:
  - LSQ if is_load | is_store.
  - Else MDU if is_muldiv.
  - Else ALU.
  - Exactly one class per instruction.
- Slot k dispatches when all of these hold:
  - it is valid;
  - slot k-1 dispatches (slot 0 has no predecessor);
  - (k+1) ≤ rob_credit;
  - the count of same-class slots in 0..k ≤ that class's credit.
- The first blocked slot blocks all younger slots. n_disp = number dispatched.
- Outputs for a dispatched slot k: class we[k]=1, rob_we[k]=1, disp_rob_tag[k] = rob_tail + k (mod ROB_DEPTH). All other we bits are 0.
- ROB entry for each slot:
  - is_valid=1, is_ready=0, has_exception=0.
  - pc, rd, has_rd, is_branch, is_jump, is_store copied from the instruction.
  - All other fields 0.
- Next state, no flush:
  - rob_tail += n_disp, wrapping.
  - Undispatched slots shift down by n_disp, staying compacted.
- in_rdy = !rst && !flush && (all valid slots dispatch this cycle). This includes the empty-buffer case.
- On accept, the slots load in_insts with valid[k] = in_insts[k].is_valid. This replaces the old slots, which are fully drained this cycle.
- A bundle with no valid instructions is accepted and leaves the buffer empty.
- stall_cycles increments, saturating at 2^32-1, in every cycle where the buffer is non-empty and n_disp < valid count.
- flush has the highest priority:
  - all we outputs and in_rdy are 0 that cycle;
  - next state: all slots invalid, rob_tail = flush_rob_tail;
  - stall_cycles is not cleared.
- Reset: all slots invalid, rob_tail=0, stall_cycles=0. While rst=1, all we outputs and in_rdy are 0.

## Timing
- Outputs are combinational from registered slots and the same-cycle credits. There are no combinational paths from in_insts to any output.
- Latency: a bundle accepted at edge t can dispatch in cycle t+1 at the earliest.
- A fully drained buffer accepts the next bundle in the same cycle, giving one bundle per cycle sustained.
- Credits must reflect state before this cycle's writes. Queues account for we at the edge.
- Wrap-around: with tail=ROB_DEPTH-1 and W=2, tags are ROB_DEPTH-1 and 0, and the next tail is 1.
- rst and flush in the same cycle: rst wins, and tail=0.

## Test plan
- Reset then idle, W=2: all we outputs 0, in_rdy=1, rob_tail=0, stall_cycles=0.
- Two ALU instructions, all credits=2: next cycle alu_rs_we=11, rob_we=11, tags 0 and 1; a new bundle is accepted the same cycle; tail=2.
- ALU+ALU with alu_rs_credit=1: slot0 dispatches and slot1 shifts to slot0. Next cycle, with credit=1, it dispatches with tag 1; stall_cycles=1; in_rdy=0 in the first cycle only.
- LSQ+ALU with lsq_credit=0: nothing dispatches (in-order block) despite alu_rs_credit=2; stall_cycles counts until lsq_credit becomes ≥1.
- rob_credit=1 with MDU+ALU: only the MDU dispatches. Tail at 31 (ROB_DEPTH=32) with two dispatches: tags 31 and 0, tail becomes 1.
- flush with a half-drained buffer and flush_rob_tail=7: all we outputs 0, buffer empty next cycle, next dispatch tagged 7.

Source files
------------

// File: rtl/dispatch_buffer.sv
// Dispatch stage: holds one renamed bundle, routes the oldest in-order prefix to the
// issue queues under per-queue credits, and owns the ROB tail pointer.
package dispatch_buffer_pkg;
  typedef struct packed {
    logic        is_valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        has_rd;
    logic        is_branch;
    logic        is_jump;
    logic        is_load;
    logic        is_store;
    logic        is_muldiv;
    logic [5:0]  prd;
  } renamed_inst_t;

  typedef struct packed {
    logic        is_valid;
    logic        is_ready;
    logic        has_exception;
    logic [3:0]  exc_cause;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        has_rd;
    logic        is_branch;
    logic        is_jump;
    logic        is_store;
  } rob_entry_t;
endpackage

module dispatch_buffer
  import dispatch_buffer_pkg::*;
#(
  parameter int DISPATCH_WIDTH = 2,
  parameter int ROB_DEPTH      = 32,
  parameter int ROB_IDX_W      = $clog2(ROB_DEPTH),
  parameter int CREDIT_W       = $clog2(DISPATCH_WIDTH + 1)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         flush,
  input  logic [ROB_IDX_W-1:0]                         flush_rob_tail,
  input  logic                                         in_valid,
  output logic                                         in_rdy,
  input  renamed_inst_t [DISPATCH_WIDTH-1:0]           in_insts,
  input  logic [CREDIT_W-1:0]                          alu_rs_credit,
  input  logic [CREDIT_W-1:0]                          mdu_rs_credit,
  input  logic [CREDIT_W-1:0]                          lsq_credit,
  input  logic [CREDIT_W-1:0]                          rob_credit,
  output logic [DISPATCH_WIDTH-1:0]                    alu_rs_we,
  output logic [DISPATCH_WIDTH-1:0]                    mdu_rs_we,
  output logic [DISPATCH_WIDTH-1:0]                    lsq_we,
  output renamed_inst_t [DISPATCH_WIDTH-1:0]           alu_rs_entries,
  output renamed_inst_t [DISPATCH_WIDTH-1:0]           mdu_rs_entries,
  output renamed_inst_t [DISPATCH_WIDTH-1:0]           lsq_entries,
  output logic [DISPATCH_WIDTH-1:0]                    rob_we,
  output rob_entry_t [DISPATCH_WIDTH-1:0]              rob_entries,
  output logic [DISPATCH_WIDTH-1:0][ROB_IDX_W-1:0]     disp_rob_tag,
  output logic [31:0]                                  stall_cycles
);
  localparam int W = DISPATCH_WIDTH;

  renamed_inst_t [W-1:0] slot_q, slot_d;
  logic [W-1:0]          vld_q, vld_d;
  logic [ROB_IDX_W-1:0]  tail_q, tail_d;
  logic [31:0]           stall_q, stall_d;

  logic [W-1:0] disp, is_alu, is_mdu, is_lsq;
  logic         all_disp;
  int           n_disp, n_valid;

  // Dispatch chain: a slot goes only if every older slot went and its class/ROB credit holds.
  always_comb begin
    int  c_alu, c_mdu, c_lsq;
    logic chain, ok;
    disp     = '0;
    is_alu   = '0;
    is_mdu   = '0;
    is_lsq   = '0;
    all_disp = 1'b1;
    n_disp   = 0;
    n_valid  = 0;
    c_alu    = 0;
    c_mdu    = 0;
    c_lsq    = 0;
    chain    = !rst && !flush;
    for (int k = 0; k < W; k++) begin
      is_lsq[k] = slot_q[k].is_load | slot_q[k].is_store;
      is_mdu[k] = !is_lsq[k] && slot_q[k].is_muldiv;
      is_alu[k] = !is_lsq[k] && !slot_q[k].is_muldiv;
      if (vld_q[k]) begin
        n_valid++;
        if (is_lsq[k]) c_lsq++;
        if (is_mdu[k]) c_mdu++;
        if (is_alu[k]) c_alu++;
      end
      ok = vld_q[k] && chain && ((k + 1) <= int'(rob_credit)) &&
           (!is_lsq[k] || c_lsq <= int'(lsq_credit)) &&
           (!is_mdu[k] || c_mdu <= int'(mdu_rs_credit)) &&
           (!is_alu[k] || c_alu <= int'(alu_rs_credit));
      disp[k] = ok;
      chain   = ok;
      if (ok) n_disp++;
      if (vld_q[k] && !ok) all_disp = 1'b0;
    end
  end

  assign in_rdy = !rst && !flush && all_disp;

  always_comb begin
    for (int k = 0; k < W; k++) begin
      alu_rs_we[k]    = disp[k] & is_alu[k];
      mdu_rs_we[k]    = disp[k] & is_mdu[k];
      lsq_we[k]       = disp[k] & is_lsq[k];
      rob_we[k]       = disp[k];
      disp_rob_tag[k] = tail_q + ROB_IDX_W'(k);
      rob_entries[k]           = '0;
      rob_entries[k].is_valid  = 1'b1;
      rob_entries[k].pc        = slot_q[k].pc;
      rob_entries[k].rd        = slot_q[k].rd;
      rob_entries[k].has_rd    = slot_q[k].has_rd;
      rob_entries[k].is_branch = slot_q[k].is_branch;
      rob_entries[k].is_jump   = slot_q[k].is_jump;
      rob_entries[k].is_store  = slot_q[k].is_store;
    end
  end

  assign alu_rs_entries = slot_q;
  assign mdu_rs_entries = slot_q;
  assign lsq_entries    = slot_q;
  assign stall_cycles   = stall_q;

  always_comb begin
    slot_d  = slot_q;
    vld_d   = '0;
    tail_d  = tail_q + ROB_IDX_W'(n_disp);
    stall_d = stall_q;
    if (vld_q != '0 && n_disp < n_valid && stall_q != 32'hFFFF_FFFF)
      stall_d = stall_q + 32'd1;
    // Leftover slots slide down so the buffer stays compacted at slot 0.
    for (int j = 0; j < W; j++) begin
      if (j + n_disp < W) begin
        slot_d[j] = slot_q[j + n_disp];
        vld_d[j]  = vld_q[j + n_disp];
      end
    end
    if (in_valid && in_rdy) begin
      slot_d = in_insts;
      for (int k = 0; k < W; k++) vld_d[k] = in_insts[k].is_valid;
    end
    if (flush) begin
      vld_d  = '0;
      tail_d = flush_rob_tail;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '0;
      vld_q   <= '0;
      tail_q  <= '0;
      stall_q <= '0;
    end else begin
      slot_q  <= slot_d;
      vld_q   <= vld_d;
      tail_q  <= tail_d;
      stall_q <= stall_d;
    end
  end
endmodule
